// File: rtl/krp8_ifetch_prefetch.sv
// krp8_ifetch_prefetch: sequential instruction prefetch FIFO between core fetch port and 1-cycle SRAM
module krp8_ifetch_prefetch #(
    parameter int DEPTH = 4,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ireq,
    input  logic [29:0]   iaddr,
    output logic          ivalid,
    output logic [31:0]   instr,
    output logic          mem_csn,
    output logic [AW-1:0] mem_a,
    input  logic [31:0]   mem_dout
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fa [DEPTH];
    logic [31:0]   fd [DEPTH];
    logic [PW-1:0] rp, wp;
    logic [CW-1:0] count;
    logic [AW-1:0] nfa, ra, a_q, rw;
    logic          rv, hit, byp, miss, issue, push;
    logic          unused_addr_bits;

    assign rw = iaddr[AW+1:2];
    assign unused_addr_bits = ^{iaddr[29:AW+2], iaddr[1:0]};

    // classify the request, drive the core and SRAM, decide prefetch and push
    always_comb begin
        hit     = ireq && (count != '0) && (fa[rp] == rw);
        byp     = ireq && (count == '0) && rv && (ra == rw);
        miss    = ireq && !hit && !byp;
        issue   = !miss && ((count + CW'(rv)) < CW'(DEPTH));
        push    = rv && !byp && !miss;
        ivalid  = rst_n && (hit || byp);
        instr   = hit ? fd[rp] : byp ? mem_dout : '0;
        mem_csn = !(rst_n && (miss || issue));
        mem_a   = miss ? rw : issue ? nfa : a_q;
    end

    // pointers, occupancy, in-flight read tracking and next-fetch address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
            rv    <= 1'b0;
            ra    <= '0;
            nfa   <= '0;
            a_q   <= '0;
        end else begin
            a_q <= mem_a;
            if (miss) begin
                rp    <= '0;
                wp    <= '0;
                count <= '0;
                rv    <= 1'b1;
                ra    <= rw;
                nfa   <= rw + 1'b1;
            end else begin
                rp    <= rp + PW'(hit);
                wp    <= wp + PW'(push);
                count <= count + CW'(push) - CW'(hit);
                rv    <= issue;
                if (issue) begin
                    ra  <= nfa;
                    nfa <= nfa + 1'b1;
                end
            end
        end
    end

    // FIFO storage captures the returning SRAM word with its address
    always_ff @(posedge clk) begin
        if (push) begin
            fa[wp] <= ra;
            fd[wp] <= mem_dout;
        end
    end
endmodule

// File: tb/tb_krp8_ifetch_prefetch.sv
// tb_krp8_ifetch_prefetch: directed and randomized checks against a queue-based fetch model
module tb_krp8_ifetch_prefetch;
    localparam int DEPTH = 4;
    localparam int AW    = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ireq = 1'b0;
    logic [29:0]   iaddr = '0;
    logic          ivalid;
    logic [31:0]   instr;
    logic          mem_csn;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_dout = '0;
    logic [31:0]   mem [1<<AW];
    int            checks = 0;
    int            errors = 0;

    logic [AW-1:0] q[$];
    logic          m_rv = 1'b0;
    logic [AW-1:0] m_ra = '0;
    logic [AW-1:0] m_nfa = '0;

    krp8_ifetch_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .ireq(ireq), .iaddr(iaddr),
        .ivalid(ivalid), .instr(instr), .mem_csn(mem_csn),
        .mem_a(mem_a), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // synchronous SRAM, one cycle read latency
    always @(posedge clk) if (!mem_csn) mem_dout <= mem[mem_a];

    function automatic void model_reset();
        q.delete();
        m_rv  = 1'b0;
        m_ra  = '0;
        m_nfa = '0;
    endfunction

    function automatic void model_step();
        logic [AW-1:0] rw;
        logic hit, byp, miss, iss;
        rw   = iaddr[AW+1:2];
        hit  = (q.size() > 0) ? (ireq && q[0] == rw) : 1'b0;
        byp  = ireq && q.size() == 0 && m_rv && m_ra == rw;
        miss = ireq && !hit && !byp;
        if (miss) begin
            q.delete();
            m_rv  = 1'b1;
            m_ra  = rw;
            m_nfa = rw + 1'b1;
        end else begin
            iss = (q.size() + int'(m_rv)) < DEPTH;
            if (hit) void'(q.pop_front());
            if (m_rv && !byp) q.push_back(m_ra);
            m_rv = iss;
            if (iss) begin
                m_ra  = m_nfa;
                m_nfa = m_nfa + 1'b1;
            end
        end
    endfunction

    function automatic void expect_now(output logic ev, output logic [31:0] ei,
                                       output logic ecsn, output logic [AW-1:0] ea);
        logic [AW-1:0] rw;
        logic hit, byp, miss, iss;
        rw   = iaddr[AW+1:2];
        hit  = (q.size() > 0) ? (ireq && q[0] == rw) : 1'b0;
        byp  = ireq && q.size() == 0 && m_rv && m_ra == rw;
        miss = ireq && !hit && !byp;
        iss  = !miss && ((q.size() + int'(m_rv)) < DEPTH);
        ev   = rst_n && (hit || byp);
        ei   = ev ? mem[rw] : 32'h0;
        ecsn = !(rst_n && (miss || iss));
        ea   = miss ? rw : m_nfa;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ireq  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic preload_seq();
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + i;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ireq  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            iaddr = 30'($urandom);
            @(negedge clk);
            checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL reset_ivalid: got %b want 0", ivalid); end
            checks++; if (mem_csn !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b want 1", mem_csn); end
            checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
            tick();
        end
        ireq = 1'b0;
    endtask

    task automatic test_boot_fill();
        logic ev; logic [31:0] ei; logic ecsn; logic [AW-1:0] ea;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            expect_now(ev, ei, ecsn, ea);
            checks++; if (mem_csn !== (c >= 4)) begin errors++; $display("FAIL boot_csn c%0d: got %b want %b", c, mem_csn, c >= 4); end
            checks++; if (mem_csn !== ecsn) begin errors++; $display("FAIL boot_csn_model c%0d: got %b want %b", c, mem_csn, ecsn); end
            if (c < 4) begin
                checks++; if (mem_a !== AW'(c)) begin errors++; $display("FAIL boot_addr c%0d: got %h want %h", c, mem_a, c); end
            end
            checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL boot_ivalid c%0d: got %b want 0", c, ivalid); end
            tick();
        end
    endtask

    task automatic test_streaming();
        logic ev; logic [31:0] ei; logic ecsn; logic [AW-1:0] ea;
        for (int k = 0; k < 12; k++) begin
            ireq  = 1'b1;
            iaddr = 30'(k * 4);
            @(negedge clk);
            expect_now(ev, ei, ecsn, ea);
            checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL stream_ivalid k%0d: got %b want 1", k, ivalid); end
            checks++; if (instr !== 32'hA000_0000 + k) begin errors++; $display("FAIL stream_instr k%0d: got %h want %h", k, instr, 32'hA000_0000 + k); end
            checks++; if (mem_csn !== (k == 0)) begin errors++; $display("FAIL stream_csn k%0d: got %b want %b", k, mem_csn, k == 0); end
            if (!ecsn) begin
                checks++; if (mem_a !== ea) begin errors++; $display("FAIL stream_addr k%0d: got %h want %h", k, mem_a, ea); end
            end
            tick();
        end
        ireq = 1'b0;
    endtask

    task automatic test_branch();
        do_reset();
        repeat (6) tick();
        for (int k = 0; k < 4; k++) begin
            ireq  = 1'b1;
            iaddr = 30'(k * 4);
            tick();
        end
        ireq = 1'b0;
        repeat (3) tick();
        ireq  = 1'b1;
        iaddr = 30'h100;
        @(negedge clk);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL branch_miss_ivalid: got %b want 0", ivalid); end
        checks++; if (mem_csn !== 1'b0) begin errors++; $display("FAIL branch_miss_csn: got %b want 0", mem_csn); end
        checks++; if (mem_a !== 10'h040) begin errors++; $display("FAIL branch_miss_addr: got %h want 040", mem_a); end
        tick();
        @(negedge clk);
        checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL branch_byp_ivalid: got %b want 1", ivalid); end
        checks++; if (instr !== 32'hA000_0040) begin errors++; $display("FAIL branch_byp_instr: got %h want A0000040", instr); end
        tick();
        iaddr = 30'h104;
        @(negedge clk);
        checks++; if (ivalid !== 1'b1) begin errors++; $display("FAIL branch_next_ivalid: got %b want 1", ivalid); end
        checks++; if (instr !== 32'hA000_0041) begin errors++; $display("FAIL branch_next_instr: got %h want A0000041", instr); end
        tick();
        ireq = 1'b0;
    endtask

    task automatic test_cold_miss();
        do_reset();
        tick();
        ireq  = 1'b1;
        iaddr = 30'h20;
        @(negedge clk);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL cold_ivalid: got %b want 0", ivalid); end
        checks++; if (mem_csn !== 1'b0 || mem_a !== 10'h008) begin errors++; $display("FAIL cold_read: got csn=%b a=%h want csn=0 a=008", mem_csn, mem_a); end
        tick();
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || instr !== 32'hA000_0008) begin errors++; $display("FAIL cold_byp: got v=%b i=%h want v=1 i=A0000008", ivalid, instr); end
        tick();
        iaddr = 30'h0;
        @(negedge clk);
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL cold_discard: got ivalid=%b want 0", ivalid); end
        checks++; if (mem_csn !== 1'b0 || mem_a !== 10'h000) begin errors++; $display("FAIL cold_refetch: got csn=%b a=%h want csn=0 a=000", mem_csn, mem_a); end
        tick();
        ireq = 1'b0;
    endtask

    task automatic test_wrap();
        do_reset();
        ireq  = 1'b1;
        iaddr = 30'hFF8;
        @(negedge clk);
        checks++; if (ivalid !== 1'b0 || mem_a !== 10'h3FE) begin errors++; $display("FAIL wrap_miss: got v=%b a=%h want v=0 a=3FE", ivalid, mem_a); end
        tick();
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || instr !== 32'hA000_03FE) begin errors++; $display("FAIL wrap_3fe: got v=%b i=%h want v=1 i=A00003FE", ivalid, instr); end
        tick();
        iaddr = 30'hFFC;
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || instr !== 32'hA000_03FF) begin errors++; $display("FAIL wrap_3ff: got v=%b i=%h want v=1 i=A00003FF", ivalid, instr); end
        checks++; if (mem_csn !== 1'b0 || mem_a !== 10'h000) begin errors++; $display("FAIL wrap_prefetch: got csn=%b a=%h want csn=0 a=000", mem_csn, mem_a); end
        tick();
        iaddr = 30'h1000;
        @(negedge clk);
        checks++; if (ivalid !== 1'b1 || instr !== 32'hA000_0000) begin errors++; $display("FAIL wrap_alias: got v=%b i=%h want v=1 i=A0000000", ivalid, instr); end
        tick();
        ireq = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (4) tick();
        rst_n = 1'b0;
        ireq  = 1'b1;
        iaddr = 30'($urandom);
        #1;
        checks++; if (mem_csn !== 1'b1) begin errors++; $display("FAIL midreset_csn: got %b want 1", mem_csn); end
        checks++; if (ivalid !== 1'b0) begin errors++; $display("FAIL midreset_ivalid: got %b want 0", ivalid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ireq  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (mem_csn !== 1'b0 || mem_a !== AW'(c)) begin errors++; $display("FAIL midreset_refill c%0d: got csn=%b a=%h want csn=0 a=%h", c, mem_csn, mem_a, c); end
            tick();
        end
    endtask

    task automatic test_random();
        logic ev; logic [31:0] ei; logic ecsn; logic [AW-1:0] ea;
        logic [29:0] pc;
        int r;
        do_reset();
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        pc = '0;
        for (int n = 0; n < 400; n++) begin
            r     = int'($urandom_range(0, 99));
            ireq  = (r >= 15);
            if (r >= 90) pc = 30'($urandom);
            iaddr = pc;
            @(negedge clk);
            expect_now(ev, ei, ecsn, ea);
            checks++; if (ivalid !== ev) begin errors++; $display("FAIL rnd_ivalid n%0d: got %b want %b", n, ivalid, ev); end
            checks++; if (instr !== ei) begin errors++; $display("FAIL rnd_instr n%0d: got %h want %h", n, instr, ei); end
            checks++; if (mem_csn !== ecsn) begin errors++; $display("FAIL rnd_csn n%0d: got %b want %b", n, mem_csn, ecsn); end
            if (!ecsn) begin
                checks++; if (mem_a !== ea) begin errors++; $display("FAIL rnd_addr n%0d: got %h want %h", n, mem_a, ea); end
            end
            if (ev && $urandom_range(0, 9) < 8) pc = pc + 30'd4;
            tick();
        end
        ireq = 1'b0;
    endtask

    initial begin
        preload_seq();
        #1;
        test_reset();
        test_boot_fill();
        test_streaming();
        test_branch();
        test_cold_miss();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
